// File: rtl/control_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : control_sequencer_if
// Brief    : Decode-to-execute control bundle for the control sequencer,
//            plus the shared mode / opcode / execute-command encodings.
// Revision : 1.0
// ============================================================================

`ifndef CONTROL_SEQUENCER_DEFS
`define CONTROL_SEQUENCER_DEFS
`define MODE_ARITHMETIC 2'b00
`define MODE_MEM        2'b01
`define MODE_BRANCH     2'b10
`define OP_AND 4'b0000
`define OP_EOR 4'b0001
`define OP_SUB 4'b0010
`define OP_ADD 4'b0100
`define OP_ADC 4'b0101
`define OP_SBC 4'b0110
`define OP_TST 4'b1000
`define OP_CMP 4'b1010
`define OP_ORR 4'b1100
`define OP_MOV 4'b1101
`define OP_MVN 4'b1110
`define EX_MOV 4'b0001
`define EX_ADD 4'b0010
`define EX_ADC 4'b0011
`define EX_SUB 4'b0100
`define EX_SBC 4'b0101
`define EX_AND 4'b0110
`define EX_ORR 4'b0111
`define EX_EOR 4'b1000
`define EX_MVN 4'b1001
`define EX_CMP 4'b1010
`define EX_TST 4'b1011
`define EX_LDR 4'b1100
`define EX_STR 4'b1101
`endif

interface control_sequencer_if #(
    parameter int NUM_REGS = 16,
    parameter int IDX_W    = 4,
    parameter int OFS_W    = 6
);
    logic                instr_valid;
    logic                stall;
    logic                flush;
    logic                S;
    logic [1:0]          mode;
    logic [3:0]          op_code;
    logic [NUM_REGS-1:0] reg_list;

    logic [3:0]          EX_command;
    logic                mem_read;
    logic                mem_write;
    logic                WB_en;
    logic                B;
    logic                update;
    logic                out_valid;
    logic [IDX_W-1:0]    blk_reg;
    logic [OFS_W-1:0]    blk_ofs;
    logic                blk_last;
    logic                busy;

    modport master (
        output instr_valid, stall, flush, S, mode, op_code, reg_list,
        input  EX_command, mem_read, mem_write, WB_en, B, update, out_valid,
        input  blk_reg, blk_ofs, blk_last, busy
    );

    modport slave (
        input  instr_valid, stall, flush, S, mode, op_code, reg_list,
        output EX_command, mem_read, mem_write, WB_en, B, update, out_valid,
        output blk_reg, blk_ofs, blk_last, busy
    );
endinterface

`default_nettype wire

// File: rtl/control_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : control_sequencer
// Brief    : Decode-stage control generator with a block-transfer sequencer
//            that expands a register list into one load/store beat per cycle.
// Revision : 1.0
// ============================================================================

module control_sequencer #(
    parameter int NUM_REGS = 16,
    parameter int IDX_W    = 4,
    parameter int OFS_W    = 6
) (
    input  logic               clk,
    input  logic               rst,
    control_sequencer_if.slave bus
);

    localparam logic [0:0]          c_IDLE       = 1'b0;
    localparam logic [0:0]          c_SEQ        = 1'b1;
    localparam logic [1:0]          c_MODE_BLOCK = 2'b11;
    localparam logic [NUM_REGS-1:0] c_LIST_ONE   = {{(NUM_REGS-1){1'b0}}, 1'b1};
    localparam logic [OFS_W-1:0]    c_OFS_STEP   = OFS_W'(4);

    logic [0:0]          r_state,     w_state;
    logic [NUM_REGS-1:0] r_list,      w_list;
    logic                r_load,      w_load;
    logic [3:0]          r_ex,        w_ex;
    logic                r_mem_read,  w_mem_read;
    logic                r_mem_write, w_mem_write;
    logic                r_wb_en,     w_wb_en;
    logic                r_b,         w_b;
    logic                r_update,    w_update;
    logic                r_out_valid, w_out_valid;
    logic [IDX_W-1:0]    r_blk_reg,   w_blk_reg;
    logic [OFS_W-1:0]    r_blk_ofs,   w_blk_ofs;
    logic                r_blk_last,  w_blk_last;

    // Lists with the lowest set bit removed: what is left after this beat.
    logic [NUM_REGS-1:0] w_seq_rest;
    logic [NUM_REGS-1:0] w_new_rest;

    assign w_seq_rest = r_list & (r_list - c_LIST_ONE);
    assign w_new_rest = bus.reg_list & (bus.reg_list - c_LIST_ONE);

    function automatic logic [IDX_W-1:0] f_lowest(input logic [NUM_REGS-1:0] v);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = NUM_REGS - 1; i >= 0; i--) begin
            if (v[i]) idx = IDX_W'(i);
        end
        return idx;
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= c_IDLE;
            r_list      <= '0;
            r_load      <= 1'b0;
            r_ex        <= 4'b0000;
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
            r_wb_en     <= 1'b0;
            r_b         <= 1'b0;
            r_update    <= 1'b0;
            r_out_valid <= 1'b0;
            r_blk_reg   <= '0;
            r_blk_ofs   <= '0;
            r_blk_last  <= 1'b0;
        end else begin
            r_state     <= w_state;
            r_list      <= w_list;
            r_load      <= w_load;
            r_ex        <= w_ex;
            r_mem_read  <= w_mem_read;
            r_mem_write <= w_mem_write;
            r_wb_en     <= w_wb_en;
            r_b         <= w_b;
            r_update    <= w_update;
            r_out_valid <= w_out_valid;
            r_blk_reg   <= w_blk_reg;
            r_blk_ofs   <= w_blk_ofs;
            r_blk_last  <= w_blk_last;
        end
    end

    always_comb begin
        // Holding every register is the stall behaviour.
        w_state     = r_state;
        w_list      = r_list;
        w_load      = r_load;
        w_ex        = r_ex;
        w_mem_read  = r_mem_read;
        w_mem_write = r_mem_write;
        w_wb_en     = r_wb_en;
        w_b         = r_b;
        w_update    = r_update;
        w_out_valid = r_out_valid;
        w_blk_reg   = r_blk_reg;
        w_blk_ofs   = r_blk_ofs;
        w_blk_last  = r_blk_last;

        if (bus.flush || !bus.stall) begin
            w_ex        = 4'b0000;
            w_mem_read  = 1'b0;
            w_mem_write = 1'b0;
            w_wb_en     = 1'b0;
            w_b         = 1'b0;
            w_update    = 1'b0;
            w_out_valid = 1'b0;
            w_blk_reg   = '0;
            w_blk_ofs   = '0;
            w_blk_last  = 1'b0;
        end

        if (bus.flush) begin
            w_state = c_IDLE;
            w_list  = '0;
        end else if (!bus.stall) begin
            if (r_state == c_SEQ) begin
                w_out_valid = 1'b1;
                w_ex        = r_load ? `EX_LDR : `EX_STR;
                w_mem_read  = r_load;
                w_mem_write = !r_load;
                w_wb_en     = r_load;
                w_blk_reg   = f_lowest(r_list);
                w_blk_ofs   = r_blk_ofs + c_OFS_STEP;
                w_blk_last  = (w_seq_rest == '0);
                w_list      = w_seq_rest;
                if (w_seq_rest == '0) w_state = c_IDLE;
            end else if (bus.instr_valid) begin
                w_out_valid = 1'b1;
                case (bus.mode)
                    `MODE_ARITHMETIC: begin
                        w_wb_en  = 1'b1;
                        w_update = bus.S;
                        case (bus.op_code)
                            `OP_MOV: w_ex = `EX_MOV;
                            `OP_MVN: w_ex = `EX_MVN;
                            `OP_ADD: w_ex = `EX_ADD;
                            `OP_ADC: w_ex = `EX_ADC;
                            `OP_SUB: w_ex = `EX_SUB;
                            `OP_SBC: w_ex = `EX_SBC;
                            `OP_AND: w_ex = `EX_AND;
                            `OP_ORR: w_ex = `EX_ORR;
                            `OP_EOR: w_ex = `EX_EOR;
                            `OP_CMP: begin
                                w_ex     = `EX_CMP;
                                w_wb_en  = 1'b0;
                                w_update = 1'b1;
                            end
                            `OP_TST: begin
                                w_ex     = `EX_TST;
                                w_wb_en  = 1'b0;
                                w_update = 1'b1;
                            end
                            default: begin
                                w_wb_en  = 1'b0;
                                w_update = 1'b0;
                            end
                        endcase
                    end
                    `MODE_MEM: begin
                        w_ex        = bus.S ? `EX_LDR : `EX_STR;
                        w_mem_read  = bus.S;
                        w_mem_write = !bus.S;
                        w_wb_en     = bus.S;
                    end
                    `MODE_BRANCH: begin
                        w_b = 1'b1;
                    end
                    c_MODE_BLOCK: begin
                        // An empty list is a live no-op with no beats.
                        if (bus.reg_list != '0) begin
                            w_ex        = bus.S ? `EX_LDR : `EX_STR;
                            w_mem_read  = bus.S;
                            w_mem_write = !bus.S;
                            w_wb_en     = bus.S;
                            w_blk_reg   = f_lowest(bus.reg_list);
                            if (w_new_rest == '0) begin
                                w_blk_last = 1'b1;
                            end else begin
                                w_state = c_SEQ;
                                w_list  = w_new_rest;
                                w_load  = bus.S;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.EX_command = r_ex;
    assign bus.mem_read   = r_mem_read;
    assign bus.mem_write  = r_mem_write;
    assign bus.WB_en      = r_wb_en;
    assign bus.B          = r_b;
    assign bus.update     = r_update;
    assign bus.out_valid  = r_out_valid;
    assign bus.blk_reg    = r_blk_reg;
    assign bus.blk_ofs    = r_blk_ofs;
    assign bus.blk_last   = r_blk_last;
    // Busy drops one beat early so upstream sees it before the final beat.
    assign bus.busy       = (r_state == c_SEQ) && (w_seq_rest != '0);

endmodule

`default_nettype wire

// File: tb/tb_control_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_control_sequencer
// Brief    : Self-checking bench for control_sequencer: decode table plus
//            block-transfer, stall, flush and reset sequences.
// Revision : 1.0
// ============================================================================

`ifndef CONTROL_SEQUENCER_DEFS
`define CONTROL_SEQUENCER_DEFS
`define MODE_ARITHMETIC 2'b00
`define MODE_MEM        2'b01
`define MODE_BRANCH     2'b10
`define OP_AND 4'b0000
`define OP_EOR 4'b0001
`define OP_SUB 4'b0010
`define OP_ADD 4'b0100
`define OP_ADC 4'b0101
`define OP_SBC 4'b0110
`define OP_TST 4'b1000
`define OP_CMP 4'b1010
`define OP_ORR 4'b1100
`define OP_MOV 4'b1101
`define OP_MVN 4'b1110
`define EX_MOV 4'b0001
`define EX_ADD 4'b0010
`define EX_ADC 4'b0011
`define EX_SUB 4'b0100
`define EX_SBC 4'b0101
`define EX_AND 4'b0110
`define EX_ORR 4'b0111
`define EX_EOR 4'b1000
`define EX_MVN 4'b1001
`define EX_CMP 4'b1010
`define EX_TST 4'b1011
`define EX_LDR 4'b1100
`define EX_STR 4'b1101
`endif

module tb_control_sequencer;

    localparam logic [1:0] c_BLK = 2'b11;
    localparam logic [1:0] c_AR  = `MODE_ARITHMETIC;

    typedef struct packed {
        logic [3:0] ex;
        logic       rd;
        logic       wr;
        logic       wb;
        logic       b;
        logic       upd;
        logic       ov;
        logic [3:0] rg;
        logic [5:0] ofs;
        logic       last;
        logic       busy;
    } out_t;

    typedef struct packed {
        logic        iv;
        logic        stall;
        logic        flush;
        logic        s;
        logic [1:0]  mode;
        logic [3:0]  op;
        logic [15:0] list;
    } in_t;

    typedef struct {
        string nm;
        in_t   i;
        out_t  e;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;

    vec_t  tbl[$];
    out_t  exp_q[$];
    string name_q[$];

    always #5 clk = ~clk;

    control_sequencer_if #(.NUM_REGS(16), .IDX_W(4), .OFS_W(6)) bus ();

    control_sequencer #(.NUM_REGS(16), .IDX_W(4), .OFS_W(6)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    function automatic in_t f_in(input logic iv, input logic st, input logic fl, input logic s,
                                 input logic [1:0] md, input logic [3:0] op, input logic [15:0] lst);
        in_t v;
        v.iv = iv; v.stall = st; v.flush = fl; v.s = s;
        v.mode = md; v.op = op; v.list = lst;
        return v;
    endfunction

    function automatic in_t f_ar(input logic [3:0] op, input logic s);
        return f_in(1'b1, 1'b0, 1'b0, s, c_AR, op, 16'h0000);
    endfunction

    function automatic in_t f_idle();
        return f_in(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 4'h0, 16'h0000);
    endfunction

    function automatic out_t f_ar_o(input logic [3:0] ex, input logic wb, input logic upd);
        out_t o;
        o = '0; o.ex = ex; o.wb = wb; o.upd = upd; o.ov = 1'b1;
        return o;
    endfunction

    function automatic out_t f_nop(input logic b);
        out_t o;
        o = '0; o.ov = 1'b1; o.b = b;
        return o;
    endfunction

    function automatic out_t f_beat(input logic load, input logic [3:0] rg, input logic [5:0] ofs,
                                    input logic last, input logic busy);
        out_t o;
        o = '0;
        o.ex = load ? `EX_LDR : `EX_STR;
        o.rd = load; o.wr = !load; o.wb = load; o.ov = 1'b1;
        o.rg = rg; o.ofs = ofs; o.last = last; o.busy = busy;
        return o;
    endfunction

    function automatic out_t sample();
        out_t o;
        o.ex = bus.EX_command; o.rd = bus.mem_read; o.wr = bus.mem_write;
        o.wb = bus.WB_en; o.b = bus.B; o.upd = bus.update; o.ov = bus.out_valid;
        o.rg = bus.blk_reg; o.ofs = bus.blk_ofs; o.last = bus.blk_last; o.busy = bus.busy;
        return o;
    endfunction

    function automatic string f_str(input out_t o);
        return $sformatf("ex=%h rd=%b wr=%b wb=%b B=%b upd=%b ov=%b reg=%0d ofs=%0d last=%b busy=%b",
                         o.ex, o.rd, o.wr, o.wb, o.b, o.upd, o.ov, o.rg, o.ofs, o.last, o.busy);
    endfunction

    task automatic check(input string nm, input out_t got, input out_t exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got {%s} required {%s}", nm, f_str(got), f_str(exp));
        end
    endtask

    task automatic drive(input in_t v);
        bus.instr_valid = v.iv;
        bus.stall       = v.stall;
        bus.flush       = v.flush;
        bus.S           = v.s;
        bus.mode        = v.mode;
        bus.op_code     = v.op;
        bus.reg_list    = v.list;
    endtask

    task automatic cycle(input string nm, input in_t v, input out_t e);
        drive(v);
        exp_q.push_back(e);
        name_q.push_back(nm);
        @(posedge clk);
        #1;
        check(name_q.pop_front(), sample(), exp_q.pop_front());
    endtask

    task automatic add(input string nm, input in_t i, input out_t e);
        vec_t v;
        v.nm = nm; v.i = i; v.e = e;
        tbl.push_back(v);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        add("add_s0",   f_ar(`OP_ADD, 1'b0), f_ar_o(`EX_ADD, 1'b1, 1'b0));
        add("cmp_s0",   f_ar(`OP_CMP, 1'b0), f_ar_o(`EX_CMP, 1'b0, 1'b1));
        add("mov_s1",   f_ar(`OP_MOV, 1'b1), f_ar_o(`EX_MOV, 1'b1, 1'b1));
        add("mvn_s0",   f_ar(`OP_MVN, 1'b0), f_ar_o(`EX_MVN, 1'b1, 1'b0));
        add("adc_s1",   f_ar(`OP_ADC, 1'b1), f_ar_o(`EX_ADC, 1'b1, 1'b1));
        add("sub_s0",   f_ar(`OP_SUB, 1'b0), f_ar_o(`EX_SUB, 1'b1, 1'b0));
        add("sbc_s1",   f_ar(`OP_SBC, 1'b1), f_ar_o(`EX_SBC, 1'b1, 1'b1));
        add("and_s0",   f_ar(`OP_AND, 1'b0), f_ar_o(`EX_AND, 1'b1, 1'b0));
        add("orr_s1",   f_ar(`OP_ORR, 1'b1), f_ar_o(`EX_ORR, 1'b1, 1'b1));
        add("eor_s0",   f_ar(`OP_EOR, 1'b0), f_ar_o(`EX_EOR, 1'b1, 1'b0));
        add("tst_s0",   f_ar(`OP_TST, 1'b0), f_ar_o(`EX_TST, 1'b0, 1'b1));
        add("bad_op_f", f_ar(4'b1111, 1'b0), f_nop(1'b0));
        add("bad_op_3", f_ar(4'b0011, 1'b1), f_nop(1'b0));
        add("ldr",      f_in(1'b1, 1'b0, 1'b0, 1'b1, `MODE_MEM, `OP_ADD, 16'h0000),
                        f_beat(1'b1, 4'd0, 6'd0, 1'b0, 1'b0));
        add("str",      f_in(1'b1, 1'b0, 1'b0, 1'b0, `MODE_MEM, `OP_CMP, 16'h0000),
                        f_beat(1'b0, 4'd0, 6'd0, 1'b0, 1'b0));
        add("branch",   f_in(1'b1, 1'b0, 1'b0, 1'b1, `MODE_BRANCH, `OP_CMP, 16'h0000), f_nop(1'b1));
        add("no_instr", f_idle(), '0);
        add("blk_empty", f_in(1'b1, 1'b0, 1'b0, 1'b1, c_BLK, 4'h0, 16'h0000), f_nop(1'b0));
        add("blk_one10", f_in(1'b1, 1'b0, 1'b0, 1'b1, c_BLK, 4'h0, 16'h0400),
                         f_beat(1'b1, 4'd10, 6'd0, 1'b1, 1'b0));
        add("idle_stall", f_in(1'b1, 1'b1, 1'b0, 1'b0, c_AR, `OP_ADD, 16'h0000),
                          f_beat(1'b1, 4'd10, 6'd0, 1'b1, 1'b0));
        add("blk_one0",  f_in(1'b1, 1'b0, 1'b0, 1'b0, c_BLK, 4'h0, 16'h0001),
                         f_beat(1'b0, 4'd0, 6'd0, 1'b1, 1'b0));
        add("flush_idle", f_in(1'b1, 1'b1, 1'b1, 1'b0, c_AR, `OP_ADD, 16'h0000), '0);
        add("branch2",  f_in(1'b1, 1'b0, 1'b0, 1'b0, `MODE_BRANCH, 4'h0, 16'h0000), f_nop(1'b1));
        add("hold_b",   f_in(1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 4'h0, 16'h0000), f_nop(1'b1));
        add("bubble",   f_idle(), '0);

        // Reset state
        drive(f_idle());
        repeat (2) @(posedge clk);
        #1;
        check("reset_state", sample(), '0);
        rst = 1'b1;

        for (int k = 0; k < tbl.size(); k++) cycle(tbl[k].nm, tbl[k].i, tbl[k].e);

        // a: ADD then CMP back to back
        cycle("a_add", f_ar(`OP_ADD, 1'b0), f_ar_o(`EX_ADD, 1'b1, 1'b0));
        cycle("a_cmp", f_ar(`OP_CMP, 1'b0), f_ar_o(`EX_CMP, 1'b0, 1'b1));

        // b: four-beat block load; instructions offered during SEQ are ignored
        cycle("b_beat0", f_in(1'b1, 1'b0, 1'b0, 1'b1, c_BLK, 4'h0, 16'h8025),
              f_beat(1'b1, 4'd0, 6'd0, 1'b0, 1'b1));
        cycle("b_beat1", f_ar(`OP_ADD, 1'b1), f_beat(1'b1, 4'd2, 6'd4, 1'b0, 1'b1));
        cycle("b_beat2", f_ar(`OP_ADD, 1'b1), f_beat(1'b1, 4'd5, 6'd8, 1'b0, 1'b0));
        cycle("b_beat3", f_ar(`OP_ADD, 1'b1), f_beat(1'b1, 4'd15, 6'd12, 1'b1, 1'b0));
        cycle("b_after", f_ar(`OP_MOV, 1'b0), f_ar_o(`EX_MOV, 1'b1, 1'b0));
        cycle("b_idle",  f_idle(), '0);

        // c: block store with beat 0 stalled for two cycles
        cycle("c_beat0",  f_in(1'b1, 1'b0, 1'b0, 1'b0, c_BLK, 4'h0, 16'h0006),
              f_beat(1'b0, 4'd1, 6'd0, 1'b0, 1'b0));
        cycle("c_stall1", f_in(1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 4'h0, 16'h0000),
              f_beat(1'b0, 4'd1, 6'd0, 1'b0, 1'b0));
        cycle("c_stall2", f_in(1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 4'h0, 16'h0000),
              f_beat(1'b0, 4'd1, 6'd0, 1'b0, 1'b0));
        cycle("c_beat1",  f_idle(), f_beat(1'b0, 4'd2, 6'd4, 1'b1, 1'b0));
        cycle("c_idle",   f_idle(), '0);

        // d: flush with stall after beat 1 kills regs 6 and 7
        cycle("d_beat0", f_in(1'b1, 1'b0, 1'b0, 1'b1, c_BLK, 4'h0, 16'h00F0),
              f_beat(1'b1, 4'd4, 6'd0, 1'b0, 1'b1));
        cycle("d_beat1", f_idle(), f_beat(1'b1, 4'd5, 6'd4, 1'b0, 1'b1));
        cycle("d_flush", f_in(1'b1, 1'b1, 1'b1, 1'b0, c_AR, `OP_ADD, 16'h0000), '0);
        cycle("d_after1", f_idle(), '0);
        cycle("d_after2", f_idle(), '0);

        // e: asynchronous reset between edges mid-sequence
        cycle("e_beat0", f_in(1'b1, 1'b0, 1'b0, 1'b0, c_BLK, 4'h0, 16'h00F0),
              f_beat(1'b0, 4'd4, 6'd0, 1'b0, 1'b1));
        drive(f_idle());
        #2;
        rst = 1'b0;
        #1;
        check("e_async_reset", sample(), '0);
        @(posedge clk);
        #1;
        check("e_reset_held", sample(), '0);
        #2;
        rst = 1'b1;
        for (int k = 0; k < 3; k++) cycle($sformatf("e_released%0d", k), f_idle(), '0);

        // f: empty list then undefined opcode, no beats afterwards
        cycle("f_empty",  f_in(1'b1, 1'b0, 1'b0, 1'b0, c_BLK, 4'h0, 16'h0000), f_nop(1'b0));
        cycle("f_badop",  f_ar(4'b1111, 1'b1), f_nop(1'b0));
        cycle("f_idle",   f_idle(), '0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
